// File: rtl/xbar_cfg_pkg.sv
// Shared types and sizing for the crossbar configuration loader.
package xbar_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Bits held by one SRL-based LUT in the chain.
    localparam int SRL_DEPTH = 32;

    // 3-layer crossbar of 5-input LUTs: ceil(N/5) + ceil(ceil(N/5)/5) + 1.
    function automatic int lut_count(input int n);
        int l1;
        l1 = (n + 4) / 5;
        return l1 + (l1 + 4) / 5 + 1;
    endfunction

    localparam int XBAR_INPUTS   = 125;
    localparam int DEF_CHAIN_LEN = lut_count(XBAR_INPUTS) * SRL_DEPTH;

endpackage

// File: rtl/xbar_cfg_piso.sv
// Parallel-load, serial-out word register with its remaining-bit counter.
// sout always shows the bit being presented to the chain this cycle; the
// register is cleared after the last counted bit so discarded upper bits of
// a partial word never appear on sout.
module cfg_piso #(
    parameter int WORD_W = 32,
    parameter int WB_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    input  logic [WB_W-1:0]   nbits,
    output logic              sout,
    output logic              last
);

    logic [WORD_W-1:0] sreg;
    logic [WB_W-1:0]   wbits;

    // Load a word, then shift it out LSB-first while counting down the bits to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            wbits <= '0;
        end else if (clear) begin
            sreg  <= '0;
            wbits <= '0;
        end else if (load) begin
            sreg  <= data;
            wbits <= nbits;
        end else if (shift && (wbits != '0)) begin
            wbits <= wbits - WB_W'(1);
            sreg  <= (wbits == WB_W'(1)) ? '0 : (sreg >> 1);
        end
    end

    assign sout = sreg[0];
    assign last = (wbits == WB_W'(1));

endmodule

// File: rtl/xbar_cfg_loader.sv
// Streams configuration words onto the crossbar SRL scan chain.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | no load active, SE low
//   WAIT_WORD | WORD_READY high, waiting for the next word
//   SHIFT     | SE high, one chain bit per cycle from the word register
//   DONE      | CHAIN_LEN bits shifted, DONE high until the next START
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              se,
    output logic              sin,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt
);

    localparam int               WB_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN      = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(WORD_W);

    state_t            state, state_nx;
    logic              hs, load_start, piso_last;
    logic [CNT_W-1:0]  remain;
    logic [WB_W-1:0]   load_bits;

    assign hs         = (state == WAIT_WORD) & word_valid & ~abort;
    assign load_start = start & ~abort & ((state == IDLE) | (state == DONE));
    assign remain     = LEN - bit_cnt;
    // The final word only contributes the bits still missing from the chain.
    assign load_bits  = (remain < WORD_LEN) ? WB_W'(remain) : WB_W'(WORD_W);

    cfg_piso #(
        .WORD_W (WORD_W),
        .WB_W   (WB_W)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (abort),
        .load  (hs),
        .shift ((state == SHIFT) & ~abort),
        .data  (word_data),
        .nbits (load_bits),
        .sout  (sin),
        .last  (piso_last)
    );

    // Next-state decode; abort overrides everything else.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start)      state_nx = WAIT_WORD;
                WAIT_WORD:  if (word_valid) state_nx = SHIFT;
                SHIFT: begin
                    if (piso_last)
                        state_nx = ((bit_cnt + CNT_W'(1)) == LEN) ? DONE : WAIT_WORD;
                end
                default:    state_nx = IDLE;
            endcase
        end
    end

    // State register plus outputs registered from the next state, so SE is never high outside SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            se         <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            state      <= state_nx;
            se         <= (state_nx == SHIFT);
            word_ready <= (state_nx == WAIT_WORD);
            busy       <= (state_nx == WAIT_WORD) || (state_nx == SHIFT);
            done       <= (state_nx == DONE);
            if (load_start)
                bit_cnt <= '0;
            else if ((state == SHIFT) && !abort)
                bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Bench for xbar_cfg_loader: a 40-bit chain (partial last word) and the
// default 992-bit chain feeding a 125-input 3-layer crossbar model.
module tb_xbar_cfg_loader;

    localparam int WW  = 32;
    localparam int CW  = 16;
    localparam int CLS = 40;
    localparam int CLB = 992;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    start, abort, word_valid;
    logic [1:0]    word_ready, se, sin, busy, done;
    logic [WW-1:0] word_data [2];
    logic [CW-1:0] bit_cnt [2];

    xbar_cfg_loader #(.WORD_W(WW), .CHAIN_LEN(CLS), .CNT_W(CW)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .word_valid(word_valid[0]), .word_data(word_data[0]), .word_ready(word_ready[0]),
        .se(se[0]), .sin(sin[0]), .busy(busy[0]), .done(done[0]), .bit_cnt(bit_cnt[0])
    );

    xbar_cfg_loader u_big (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .word_valid(word_valid[1]), .word_data(word_data[1]), .word_ready(word_ready[1]),
        .se(se[1]), .sin(sin[1]), .busy(busy[1]), .done(done[1]), .bit_cnt(bit_cnt[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Words offered by the driver, in order, per instance.
    logic [31:0] src [2][64];

    // Observations gathered each cycle.
    bit sin_rec [2][1024];
    int se_cnt [2], acc_n [2], busy_cnt [2], se_bad [2];
    int first_hs [2], first_se [2], last_se [2], first_done [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (se[d]) begin
                if (se_cnt[d] < 1024) sin_rec[d][se_cnt[d]] = sin[d];
                se_cnt[d]++;
                if (first_se[d] < 0) first_se[d] = cyc;
                last_se[d] = cyc;
                if (!busy[d] || word_ready[d]) se_bad[d]++;
            end
            if (busy[d]) busy_cnt[d]++;
            if (rst_n && word_valid[d] && word_ready[d] && !abort[d]) begin
                acc_n[d]++;
                if (first_hs[d] < 0) first_hs[d] = cyc;
            end
            if (done[d] && first_done[d] < 0) first_done[d] = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed no end expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear(input int d);
        se_cnt[d] = 0; acc_n[d] = 0; busy_cnt[d] = 0; se_bad[d] = 0;
        first_hs[d] = -1; first_se[d] = -1; last_se[d] = -1; first_done[d] = -1;
    endtask

    task automatic fill_rand(input int d);
        for (int i = 0; i < 64; i++) src[d][i] = $urandom;
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk); #1; start[d] = 1'b1;
        @(posedge clk); #1; start[d] = 1'b0;
        mon_clear(d);
    endtask

    // Offer src words from idx0 onward, with random idle cycles, until DONE.
    task automatic feed(input int d, input int gap_pct, input int idx0);
        int idx;
        int t;
        bit hs;
        idx = idx0;
        t = 0;
        while (done[d] !== 1'b1 && t < 4000) begin
            if ($urandom_range(99) < gap_pct) begin
                word_valid[d] = 1'b0;
                word_data[d]  = $urandom;
            end else begin
                word_valid[d] = 1'b1;
                word_data[d]  = src[d][idx];
            end
            @(negedge clk);
            hs = word_valid[d] && word_ready[d];
            @(posedge clk); #1;
            if (hs && idx < 63) idx++;
            t++;
        end
        word_valid[d] = 1'b0;
        chk("load_done", 64'(done[d]), 64'(1));
        @(negedge clk); #1;
    endtask

    task automatic run_load(input int d, input int gap_pct);
        pulse_start(d);
        feed(d, gap_pct, 0);
    endtask

    // Expected: chain receives the offered words LSB-first, truncated at cl bits.
    task automatic check_load(input int d, input int cl, input int exp_busy);
        int nbad;
        nbad = 0;
        for (int k = 0; k < cl; k++)
            if (sin_rec[d][k] !== src[d][k / 32][k % 32]) nbad++;
        chk("se_count", 64'(se_cnt[d]), 64'(cl));
        chk("words_taken", 64'(acc_n[d]), 64'((cl + 31) / 32));
        chk("stream_bits_bad", 64'(nbad), 64'(0));
        chk("bit_cnt_final", 64'(bit_cnt[d]), 64'(cl));
        chk("done_busy_se_rdy", 64'({done[d], busy[d], se[d], word_ready[d]}), 64'(4'b1000));
        chk("first_se_latency", 64'(first_se[d] - first_hs[d]), 64'(1));
        chk("done_latency", 64'(first_done[d] - last_se[d]), 64'(1));
        chk("se_outside_shift", 64'(se_bad[d]), 64'(0));
        if (exp_busy >= 0) chk("busy_cycles", 64'(busy_cnt[d]), 64'(exp_busy));
    endtask

    // Crossbar model: LUT j occupies chain positions 32j..32j+31 from the head,
    // truth-table bit a at 32j+a; stream bit k sits at position CLB-1-k.
    function automatic bit lut(input int j, input logic [4:0] a);
        return sin_rec[1][CLB - 1 - (32 * j + int'(a))];
    endfunction

    function automatic bit xbar_z(input logic [124:0] a);
        logic [24:0] l1;
        logic [4:0]  l2;
        for (int i = 0; i < 25; i++) l1[i] = lut(i, a[5 * i +: 5]);
        for (int g = 0; g < 5; g++)  l2[g] = lut(25 + g, l1[5 * g +: 5]);
        return lut(30, l2);
    endfunction

    initial begin
        bit            hs;
        int            t;
        logic [7:0]    tail;
        bit            img [CLB];
        logic [127:0]  r;
        logic [124:0]  a;

        start = '0; abort = '0; word_valid = '0;
        word_data[0] = '0; word_data[1] = '0;
        mon_clear(0); mon_clear(1);

        // reset values
        repeat (3) @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_outs", 64'({se[d], sin[d], word_ready[d], busy[d], done[d]}), 64'(0));
            chk("reset_bit_cnt", 64'(bit_cnt[d]), 64'(0));
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            chk("idle_outs", 64'({se[d], word_ready[d], busy[d], done[d], bit_cnt[d]}), 64'(0));

        // partial last word on the 40-bit chain
        src[0][0] = 32'hFFFF_FFFF;
        src[0][1] = 32'hFFFF_00FF;
        run_load(0, 0);
        check_load(0, CLS, CLS + 2);
        for (int i = 0; i < 8; i++) tail[i] = sin_rec[0][32 + i];
        chk("partial_tail", 64'(tail), 64'(8'hFF));

        // random words with gaps; START from DONE reloads
        fill_rand(0);
        run_load(0, 40);
        check_load(0, CLS, -1);

        // full default chain, always-valid
        fill_rand(1);
        src[1][0] = 32'h0000_0001;
        src[1][1] = 32'h8000_0000;
        run_load(1, 0);
        check_load(1, CLB, CLB + 31);

        // back-pressure after the first word
        fill_rand(1);
        pulse_start(1);
        word_valid[1] = 1'b1;
        word_data[1]  = src[1][0];
        hs = 0; t = 0;
        while (!hs && t < 50) begin
            @(negedge clk);
            hs = word_valid[1] && word_ready[1];
            @(posedge clk); #1;
            t++;
        end
        word_valid[1] = 1'b0;
        word_data[1]  = $urandom;
        chk("bp_first_hs", 64'(hs), 64'(1));
        t = 0;
        @(negedge clk);
        while (word_ready[1] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_stall", 64'({se[1], word_ready[1], bit_cnt[1]}), 64'({1'b0, 1'b1, 16'd32}));
        end
        @(posedge clk); #1;
        feed(1, 0, 1);
        check_load(1, CLB, CLB + 31 + 10);

        // START ignored while busy, then ABORT+START at bit 17
        pulse_start(1);
        word_valid[1] = 1'b1;
        word_data[1]  = $urandom;
        t = 0;
        while (bit_cnt[1] != 16'd5 && t < 100) begin @(posedge clk); #1; t++; end
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        chk("start_ignored_busy", 64'({busy[1], bit_cnt[1]}), 64'({1'b1, 16'd6}));
        t = 0;
        while (bit_cnt[1] != 16'd17 && t < 100) begin @(posedge clk); #1; t++; end
        chk("reach_17", 64'(bit_cnt[1]), 64'(17));
        abort[1] = 1'b1;
        start[1] = 1'b1;
        @(posedge clk); #1;
        abort[1] = 1'b0;
        start[1] = 1'b0;
        word_valid[1] = 1'b0;
        chk("abort_outs", 64'({se[1], busy[1], done[1], word_ready[1]}), 64'(0));
        repeat (3) @(posedge clk); #1;
        chk("abort_stays_idle", 64'({se[1], busy[1], done[1], word_ready[1]}), 64'(0));

        // asynchronous reset in the middle of SHIFT
        pulse_start(1);
        word_valid[1] = 1'b1;
        word_data[1]  = $urandom;
        t = 0;
        while (bit_cnt[1] != 16'd100 && t < 300) begin @(posedge clk); #1; t++; end
        chk("pre_reset_se", 64'({se[1], bit_cnt[1]}), 64'({1'b1, 16'd100}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({se[1], busy[1], word_ready[1], done[1], bit_cnt[1]}), 64'(0));
        word_valid[1] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        fill_rand(1);
        run_load(1, 20);
        check_load(1, CLB, -1);

        // crossbar end-to-end: route input 37 to Z
        for (int p = 0; p < CLB; p++) img[p] = 1'b0;
        for (int x = 0; x < 32; x++) begin
            img[32 * 7  + x] = 1'((x >> 2) & 1);
            img[32 * 26 + x] = 1'((x >> 2) & 1);
            img[32 * 30 + x] = 1'((x >> 1) & 1);
        end
        for (int w = 0; w < 31; w++)
            for (int b = 0; b < 32; b++)
                src[1][w][b] = img[CLB - 1 - (32 * w + b)];
        run_load(1, 25);
        check_load(1, CLB, -1);
        for (int i = 0; i < 16; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            a = r[124:0];
            a[37] = 1'(i & 1);
            chk("xbar_z", 64'(xbar_z(a)), 64'(a[37]));
        end
        repeat (20) @(posedge clk); #1;
        chk("se_frozen_after_done", 64'({se_cnt[1], done[1]}), 64'({32'(CLB), 1'b1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
